// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the asynchronous FIFO pointer logic.
//   DEFAULT_ADDR_WIDTH - default FIFO address width (depth = 2**ADDR_WIDTH)
//   ptr_width()        - pointer width: one extra bit beyond the address
//                        separates "full" from "empty"
//   bin2gray/gray2bin  - pointer code conversions on a 32-bit carrier; the
//                        caller zero-extends its operand and casts the result
//                        back down to the pointer width
package fifo_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bit i of the result is the XOR of g[31:i].
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// wptr_full_ctrl_if: write-side bundle between a producer, the FIFO memory and
// the write-pointer / full-flag controller.
//   master (producer side) drives : winc, ovf_clr, rptr_gray_async
//   slave  (controller)    drives : wen, waddr, wptr_gray, wfull, wafull,
//                                   wlevel, wovf
// rptr_gray_async arrives from the read domain and is not related to wclk.
interface wptr_full_ctrl_if
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic                  winc;
    logic                  ovf_clr;
    logic [PW-1:0]         rptr_gray_async;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [PW-1:0]         wptr_gray;
    logic                  wfull;
    logic                  wafull;
    logic [PW-1:0]         wlevel;
    logic                  wovf;

    modport master (
        output winc, ovf_clr, rptr_gray_async,
        input  wen, waddr, wptr_gray, wfull, wafull, wlevel, wovf
    );

    modport slave (
        input  winc, ovf_clr, rptr_gray_async,
        output wen, waddr, wptr_gray, wfull, wafull, wlevel, wovf
    );

endinterface

// File: rtl/ptr_sync2.sv
// ptr_sync2: two-flop synchroniser for a Gray-coded pointer crossing into the
// clk domain. Only one bit of a Gray pointer changes per step, so sampling a
// transition yields either the old or the new value, never a mix.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - pointer from the foreign clock domain
//   q     - synchronised pointer (second stage)
module ptr_sync2 #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] rq1;
    logic [WIDTH-1:0] rq2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= d;
            rq2 <= rq1;
        end
    end

    assign q = rq2;

endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side pointer and status controller of an asynchronous
// FIFO. Keeps the binary/Gray write pointer, gates writes when full and
// derives full, almost-full, occupancy and sticky overflow from the read
// pointer synchronised into wclk.
//   wclk   - write-domain clock (only clock)
//   wrst_n - asynchronous active-low reset
//   bus    - wptr_full_ctrl_if.slave: winc, ovf_clr, rptr_gray_async in;
//            wen, waddr, wptr_gray, wfull, wafull, wlevel, wovf out
// Build option: define WPTR_AFULL_EN to implement wafull; without it wafull
// is tied low and its register and comparator are not built.
// Requires ADDR_WIDTH >= 2 (the full pattern inverts the top two Gray bits).
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int unsigned AFULL_LEVEL = (32'd1 << ADDR_WIDTH) - 32'd2
) (
    input logic             wclk,
    input logic             wrst_n,
    wptr_full_ctrl_if.slave bus
);

    localparam int unsigned PW = ptr_width(ADDR_WIDTH);

    if (ADDR_WIDTH < 2) begin : g_bad_width
        $error("wptr_full_ctrl: ADDR_WIDTH must be at least 2");
    end
    if (AFULL_LEVEL > (32'd1 << ADDR_WIDTH)) begin : g_bad_afull
        $error("wptr_full_ctrl: AFULL_LEVEL exceeds the FIFO depth");
    end

    logic [PW-1:0] rq2;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_pat;
    logic [PW-1:0] wptr_gray;
    logic [PW-1:0] wlevel;
    logic          wen;
    logic          wfull;
    logic          wfull_next;
    logic          wovf;
    logic          wovf_next;

    ptr_sync2 #(
        .WIDTH (PW)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (bus.rptr_gray_async),
        .q     (rq2)
    );

    always_comb begin
        wen        = bus.winc & ~wfull;
        wbin_next  = wbin + {{(PW-1){1'b0}}, wen};
        wgray_next = PW'(bin2gray(32'(wbin_next)));
        rbin_s     = PW'(gray2bin(32'(rq2)));
        // Modulo-2^PW difference stays correct across the pointer wrap.
        level_next = wbin_next - rbin_s;
        // Full when the write pointer is one lap ahead: in Gray code that is
        // the read pointer with its two MSBs inverted.
        full_pat   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
        wfull_next = (wgray_next == full_pat);
        // A rejected write sets the flag; set wins over a same-cycle clear.
        wovf_next  = (bus.winc & wfull) | (wovf & ~bus.ovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin      <= '0;
            wptr_gray <= '0;
            wfull     <= 1'b0;
            wlevel    <= '0;
            wovf      <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            wfull     <= wfull_next;
            wlevel    <= level_next;
            wovf      <= wovf_next;
        end
    end

`ifdef WPTR_AFULL_EN
    logic wafull;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wafull <= 1'b0;
        end else begin
            wafull <= (32'(level_next) >= AFULL_LEVEL);
        end
    end

    assign bus.wafull = wafull;
`else
    assign bus.wafull = 1'b0;
`endif

    assign bus.wen       = wen;
    assign bus.waddr     = wbin[ADDR_WIDTH-1:0];
    assign bus.wptr_gray = wptr_gray;
    assign bus.wfull     = wfull;
    assign bus.wlevel    = wlevel;
    assign bus.wovf      = wovf;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl (ADDR_WIDTH=4, AFULL_LEVEL=14). A reference model
// tracks the write count, the two-cycle-old read pointer and the occupancy
// arithmetic; a compare process checks every output on each falling edge.
// Directed sequences pin the model with literal values; a random phase
// follows with a reader that never overtakes the writer.
module tb_wptr_full_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned PW    = AW + 1;
    localparam int          DEPTH = 16;
    localparam int          MOD   = 32;
    localparam int          AFL   = 14;
`ifdef WPTR_AFULL_EN
    localparam bit AFULL_ON = 1'b1;
`else
    localparam bit AFULL_ON = 1'b0;
`endif

    logic wclk   = 1'b0;
    logic wrst_n = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rb       = 0;

    wptr_full_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    wptr_full_ctrl #(
        .ADDR_WIDTH  (AW),
        .AFULL_LEVEL (AFL)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    // ---------------- reference model ----------------
    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary value whose Gray code matches.
    function automatic int g2b(input int g);
        for (int j = 0; j < MOD; j++) begin
            if (gray(j) == g) return j;
        end
        return -1;
    endfunction

    function automatic int mod32(input int x);
        return ((x % MOD) + MOD) % MOD;
    endfunction

    function automatic int next_wbin(input int w, input logic inc, input bit full);
        return mod32(w + ((inc && !full) ? 1 : 0));
    endfunction

    function automatic int occupancy(input int w, input logic [PW-1:0] rg);
        return mod32(w - g2b(int'(rg)));
    endfunction

    int            m_wbin  = 0;
    int            m_level = 0;
    bit            m_full  = 1'b0;
    bit            m_afull = 1'b0;
    bit            m_ovf   = 1'b0;
    logic [PW-1:0] m_rq1   = '0;
    logic [PW-1:0] m_rq2   = '0;

    // The write side sees the read pointer that was presented two edges ago.
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            m_wbin  <= 0;
            m_level <= 0;
            m_full  <= 1'b0;
            m_afull <= 1'b0;
            m_ovf   <= 1'b0;
            m_rq1   <= '0;
            m_rq2   <= '0;
        end else begin
            m_wbin  <= next_wbin(m_wbin, bus.winc, m_full);
            m_level <= occupancy(next_wbin(m_wbin, bus.winc, m_full), m_rq2);
            m_full  <= occupancy(next_wbin(m_wbin, bus.winc, m_full), m_rq2) == DEPTH;
            m_afull <= AFULL_ON &&
                       (occupancy(next_wbin(m_wbin, bus.winc, m_full), m_rq2) >= AFL);
            m_ovf   <= (bus.winc && m_full) || (m_ovf && !bus.ovf_clr);
            m_rq1   <= bus.rptr_gray_async;
            m_rq2   <= m_rq1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge wclk) begin
        if (chk_en) begin
            check("wen",       32'(bus.wen),       32'(bus.winc && !m_full));
            check("waddr",     32'(bus.waddr),     32'(m_wbin % DEPTH));
            check("wptr_gray", 32'(bus.wptr_gray), 32'(gray(m_wbin)));
            check("wfull",     32'(bus.wfull),     32'(m_full));
            check("wafull",    32'(bus.wafull),    32'(m_afull));
            check("wlevel",    32'(bus.wlevel),    32'(m_level));
            check("wovf",      32'(bus.wovf),      32'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit inc, input bit clr);
        bus.winc    = inc;
        bus.ovf_clr = clr;
        @(posedge wclk);
        #1;
    endtask

    task automatic set_rptr(input int b);
        bus.rptr_gray_async = PW'(gray(mod32(b)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.winc            = 1'b0;
        bus.ovf_clr         = 1'b0;
        bus.rptr_gray_async = '0;
        #1 wrst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(posedge wclk);
        #1;
        check("rst_waddr",  32'(bus.waddr),     32'd0);
        check("rst_gray",   32'(bus.wptr_gray), 32'd0);
        check("rst_wfull",  32'(bus.wfull),     32'd0);
        check("rst_wlevel", 32'(bus.wlevel),    32'd0);
        check("rst_wovf",   32'(bus.wovf),      32'd0);
        wrst_n = 1'b1;

        // Fill from empty with back-to-back writes.
        for (int i = 0; i < 16; i++) begin
            check("fill_waddr", 32'(bus.waddr), 32'(i));
            step(1'b1, 1'b0);
            if (i == 14) begin
                check("fill15_wfull",  32'(bus.wfull),  32'd0);
                check("fill15_wafull", 32'(bus.wafull), 32'(AFULL_ON));
            end
        end
        check("full_gray",   32'(bus.wptr_gray), 32'd24);
        check("full_wfull",  32'(bus.wfull),     32'd1);
        check("full_wlevel", 32'(bus.wlevel),    32'd16);

        // Writes while full are dropped and flag overflow.
        for (int i = 0; i < 3; i++) begin
            bus.winc = 1'b1;
            #1;
            check("ovf_wen", 32'(bus.wen), 32'd0);
            step(1'b1, 1'b0);
            check("ovf_waddr", 32'(bus.waddr),     32'd0);
            check("ovf_gray",  32'(bus.wptr_gray), 32'd24);
        end
        check("ovf_set", 32'(bus.wovf), 32'd1);
        step(1'b0, 1'b1);
        check("ovf_clr", 32'(bus.wovf), 32'd0);
        step(1'b1, 1'b1);
        check("ovf_set_wins", 32'(bus.wovf), 32'd1);
        step(1'b0, 1'b1);
        check("ovf_clr2", 32'(bus.wovf), 32'd0);

        // Reader advances to 4: visible on the third edge.
        bus.rptr_gray_async = 5'b00110;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("read_edge2_wfull", 32'(bus.wfull), 32'd1);
        step(1'b0, 1'b0);
        check("read_edge3_wfull",  32'(bus.wfull),  32'd0);
        check("read_edge3_wlevel", 32'(bus.wlevel), 32'd12);
        check("read_edge3_wafull", 32'(bus.wafull), 32'd0);

        // Reader presents wbin-1; after the two-edge lag the write side sees
        // about wbin-3. Pointer wraps 31->0 during the loop.
        set_rptr(m_wbin - 1);
        repeat (3) step(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [PW-1:0] prev;
            prev = bus.wptr_gray;
            set_rptr(m_wbin - 1);
            step(1'b1, 1'b0);
            check("wrap_gray_step", 32'($countones(prev ^ bus.wptr_gray)), 32'd1);
            check("wrap_wfull", 32'(bus.wfull), 32'd0);
            if (i >= 1) begin
                check("wrap_level_3to5",
                      32'((bus.wlevel >= 5'd3) && (bus.wlevel <= 5'd5)), 32'd1);
            end
        end

        // Drain, write to level 9, then reset asynchronously mid-burst.
        set_rptr(m_wbin);
        repeat (3) step(1'b0, 1'b0);
        repeat (9) step(1'b1, 1'b0);
        check("burst_level9", 32'(bus.wlevel), 32'd9);
        bus.winc = 1'b1;
        #2 wrst_n = 1'b0;
        #1;
        check("arst_waddr",  32'(bus.waddr),     32'd0);
        check("arst_gray",   32'(bus.wptr_gray), 32'd0);
        check("arst_wfull",  32'(bus.wfull),     32'd0);
        check("arst_wafull", 32'(bus.wafull),    32'd0);
        check("arst_wlevel", 32'(bus.wlevel),    32'd0);
        check("arst_wovf",   32'(bus.wovf),      32'd0);
        check("arst_wen",    32'(bus.wen),       32'd1);
        bus.rptr_gray_async = '0;
        @(posedge wclk);
        #3 wrst_n = 1'b1;
        check("restart_waddr0", 32'(bus.waddr), 32'd0);
        step(1'b1, 1'b0);
        check("restart_waddr1", 32'(bus.waddr), 32'd1);

        // Random traffic: slow reader first (fills, overflows), then fast.
        rb = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 200; i++) begin
                if (mod32(m_wbin - rb) > 0 &&
                    $urandom_range(0, 3) < ((ph == 0) ? 32'd1 : 32'd3)) begin
                    rb = mod32(rb + 1);
                end
                set_rptr(rb);
                step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, FIFO address width; depth = 2^ADDR_WIDTH.
REQ-002 Parameter AFULL_LEVEL, default 2^ADDR_WIDTH-2, occupancy at or above which wafull asserts.
REQ-003 Pointer width PW = ADDR_WIDTH+1 everywhere below.
REQ-004 wclk  input  1  write-domain clock; the block's only clock.
REQ-005 wrst_n  input  1  reset, asynchronous, active-low.
REQ-006 winc  input  1  write request from the producer.
REQ-007 rptr_gray_async  input  PW  read-domain Gray pointer, asynchronous to wclk.
REQ-008 ovf_clr  input  1  clears the sticky overflow flag.
REQ-009 wen  output  1  write strobe to the memory.
REQ-010 waddr  output  ADDR_WIDTH  memory write address.
REQ-011 wptr_gray  output  PW  registered write Gray pointer, to be synchronised by the read domain.
REQ-012 wfull  output  1  registered full flag.
REQ-013 wafull  output  1  registered almost-full flag.
REQ-014 wlevel  output  PW  registered occupancy, 0..2^ADDR_WIDTH.
REQ-015 wovf  output  1  sticky overflow flag.

Function
REQ-016 rptr_gray_async passes through a two-flop synchroniser (rq1, rq2) on wclk; only rq2 is used downstream.
REQ-017 wen = winc & ~wfull, combinational.
REQ-018 The binary write pointer wbin (PW bits) increments by 1 on each wclk edge where wen=1, wrapping modulo 2^PW.
REQ-019 waddr = wbin[ADDR_WIDTH-1:0].
REQ-020 wptr_gray is registered as gray(wbin_next), gray(x) = x ^ (x>>1); it changes by exactly one bit per increment.
REQ-021 wfull is registered as (gray(wbin_next) == {~rq2[PW-1:PW-2], rq2[PW-3:0]}).
REQ-022 rq2 is converted to binary rbin_s (bit i = XOR of rq2[PW-1:i]) combinationally.
REQ-023 wlevel is registered as (wbin_next - rbin_s) modulo 2^PW.
REQ-024 wafull is registered as (level_next >= AFULL_LEVEL).
REQ-025 winc=1 while wfull=1: no pointer change, wen=0, wovf sets on that edge.
REQ-026 wovf holds until ovf_clr=1; a simultaneous set and clear leaves wovf=1 (set wins).
REQ-027 Flags are pessimistic: a read becomes visible 2-3 wclk cycles late; wfull deasserts no earlier than the third edge after rptr_gray_async changes.
REQ-028 wbin wraps 2^PW-1 -> 0 with no glitch on wfull or wlevel.

Reset
REQ-029 wrst_n=0 asynchronously clears wbin, wptr_gray, rq1, rq2, wfull, wafull, wlevel and wovf to 0.
REQ-030 wen follows REQ-017 during reset; the memory ignores it because wfull=0 and the pointer is held.
REQ-031 Reset deasserting mid-operation restarts from empty; the read side resets together by system rule.

Configuration
REQ-032 Macro WPTR_AFULL_EN defined: wafull is computed per REQ-024.
REQ-033 Macro WPTR_AFULL_EN undefined: wafull is tied to 0, its register and comparator are absent, and the port remains.

Structure
REQ-034 Package fifo_pkg holds PW derivation, the gray/bin conversion functions and the default ADDR_WIDTH.
REQ-035 One sub-module, ptr_sync2 (parameterised two-flop synchroniser, async active-low reset), implements REQ-016.
REQ-036 All other logic is flat in wptr_full_ctrl.

Verification (ADDR_WIDTH=4, AFULL_LEVEL=14, rptr_gray_async=0 unless stated)
REQ-037 Reset then 16 back-to-back winc -> waddr 0..15, wptr_gray after the 16th = 5'b11000, wfull=1 on the 16th edge, wlevel=16.
REQ-038 Full, then 3 more winc -> wen=0, wbin unchanged, wovf=1; ovf_clr pulse -> wovf=0; ovf_clr with winc on the same edge -> wovf stays 1.
REQ-039 Full, then rptr_gray_async set to gray(4)=5'b00110 -> wfull=0 and wlevel=12 on the third edge; wafull=0 (level 12 < 14).
REQ-040 Loop 40 writes with rptr tracking wbin-3 -> wbin wraps 31->0; wlevel stays 3-5; wfull never asserts; wptr_gray Hamming step = 1 every write.
REQ-041 wrst_n pulsed low asynchronously mid-burst at level 9 -> all outputs 0 immediately; writing resumes at waddr=0.
REQ-042 Build without WPTR_AFULL_EN, 15 writes -> wafull=0 throughout; other outputs identical to the build with the macro.
